n_bit_addsub_pipe: RTL and testbench

N_BIT_ADDSUB_PIPE -- requirements
Module: n_bit_addsub_pipe

---
 rtl/n_bit_addsub_pipe.sv | 162 ++++++++++++++++
 tb/tb_n_bit_addsub_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n_bit_addsub_pipe.sv
// Pipelined N-bit adder/subtractor with valid/ready handshake and a single-slot accumulator.
// Define ADDER_SAT_EN to saturate s on signed overflow; c_out and ovf always report raw values.
module n_bit_addsub_pipe #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    input  logic         sub,
    input  logic         acc_mode,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ovf
);
    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    logic         advance;
    logic         accept;
    logic         out_xfer;
    logic         last_accm;
    logic [N-1:0] acc_q;
    logic         acc_busy_q;
    logic [N-1:0] y_sel;
    logic [N-1:0] y_eff;
    logic [N-1:0] s_q;
    logic         c_out_q;
    logic         ovf_q;

    // The whole pipeline moves as one unit, so a stalled output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !acc_busy_q && !rst;
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign y_sel    = acc_mode ? acc_q : y;
    assign y_eff    = sub ? ~y_sel : y_sel;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Operand remainders shrink by one slice per stage; bit 0 is always this stage's slice.
            localparam int RW = N - gi * W;

            logic                  valid_q;
            logic                  accm_q;
            logic [RW-1:0]         x_rem;
            logic [RW-1:0]         y_rem;
            logic                  cin;
            logic                  vin;
            logic                  am_in;
            logic [W:0]            slice_sum;
            logic [(gi+1)*W-1:0]   psum_d;

            assign slice_sum = {1'b0, x_rem[W-1:0]} + {1'b0, y_rem[W-1:0]} + {{W{1'b0}}, cin};

            if (gi == 0) begin : g_head
                assign x_rem  = x;
                assign y_rem  = y_eff;
                assign cin    = sub | c_in;
                assign vin    = accept;
                assign am_in  = acc_mode;
                assign psum_d = slice_sum[W-1:0];
            end else begin : g_tail
                assign x_rem  = g_stage[gi-1].g_pass.x_q;
                assign y_rem  = g_stage[gi-1].g_pass.y_q;
                assign cin    = g_stage[gi-1].g_pass.carry_q;
                assign vin    = g_stage[gi-1].valid_q;
                assign am_in  = g_stage[gi-1].accm_q;
                assign psum_d = {slice_sum[W-1:0], g_stage[gi-1].g_pass.sum_q};
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    accm_q  <= 1'b0;
                end else if (advance) begin
                    valid_q <= vin;
                    accm_q  <= am_in;
                end
            end

            if (gi < L) begin : g_pass
                logic [RW-W-1:0]     x_q;
                logic [RW-W-1:0]     y_q;
                logic [(gi+1)*W-1:0] sum_q;
                logic                carry_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        x_q     <= '0;
                        y_q     <= '0;
                        sum_q   <= '0;
                        carry_q <= 1'b0;
                    end else if (advance) begin
                        x_q     <= x_rem[RW-1:W];
                        y_q     <= y_rem[RW-1:W];
                        sum_q   <= psum_d;
                        carry_q <= slice_sum[W];
                    end
                end
            end else begin : g_last
                logic [N-1:0] s_d;
                logic         ovf_d;

                always_comb begin
                    ovf_d = (x_rem[W-1] == y_rem[W-1]) && (psum_d[N-1] != x_rem[W-1]);
                    s_d   = psum_d;
`ifdef ADDER_SAT_EN
                    if (ovf_d) begin
                        s_d = x_rem[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                    end
`endif
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        s_q     <= '0;
                        c_out_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end else if (advance) begin
                        s_q     <= s_d;
                        c_out_q <= slice_sum[W];
                        ovf_q   <= ovf_d;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[L].valid_q;
    assign last_accm = g_stage[L].accm_q;
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

    // acc_clr is applied last so it wins over a same-cycle result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            acc_busy_q <= 1'b0;
        end else begin
            if (accept && acc_mode) begin
                acc_busy_q <= 1'b1;
            end
            if (out_xfer && last_accm) begin
                acc_busy_q <= 1'b0;
                acc_q      <= s_q;
            end
            if (acc_clr) begin
                acc_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_n_bit_addsub_pipe.sv
// Randomized and directed bench for n_bit_addsub_pipe (N=8, STAGES=2) with a signed-arithmetic model.
// Build with ADDER_SAT_EN defined to check the saturating variant.
module tb_n_bit_addsub_pipe;
    localparam int N      = 8;
    localparam int STAGES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] x = '0;
    logic [7:0] y = '0;
    logic       c_in = 1'b0;
    logic       sub = 1'b0;
    logic       acc_mode = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] s;
    logic       c_out;
    logic       ovf;

    always #5 clk = ~clk;

    n_bit_addsub_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .c_in(c_in), .sub(sub), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
    );

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       ovf;
        logic       am;
    } res_t;

    res_t       exp_q[$];
    logic [7:0] m_acc = '0;
    bit         m_busy = 0;
    int         checks = 0;
    int         failures = 0;

    logic       ob_ov, ob_ir, ob_c, ob_ovf, ex_ir;
    logic [7:0] ob_s;
    bit         ob_acc, ob_xfer, ex_have;
    res_t       ex;

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic ci, input logic sb, input logic am);
        res_t r;
        int sa, sbv, ua, ub, res;
        sa  = $signed(a);
        sbv = $signed(b);
        ua  = a;
        ub  = b;
        if (sb) begin
            res = sa - sbv;
            r.c = (ua >= ub);
        end else begin
            res = sa + sbv + int'(ci);
            r.c = (ua + ub + int'(ci)) > 255;
        end
        r.ovf = (res > 127) || (res < -128);
        r.s   = 8'(res);
`ifdef ADDER_SAT_EN
        if (r.ovf) r.s = (res > 127) ? 8'h7F : 8'h80;
`endif
        r.am = am;
        return r;
    endfunction

    // Drives one cycle from a negedge, samples outputs 1ns later and advances the model.
    task automatic step(input logic iv, input logic [7:0] ix, input logic [7:0] iy,
                        input logic ici, input logic isub, input logic iam,
                        input logic iclr, input logic ior);
        in_valid = iv; x = ix; y = iy; c_in = ici; sub = isub;
        acc_mode = iam; acc_clr = iclr; out_ready = ior;
        #1;
        ob_ov = out_valid; ob_ir = in_ready; ob_s = s; ob_c = c_out; ob_ovf = ovf;
        ob_acc  = iv && in_ready && !rst;
        ob_xfer = out_valid && ior && !rst;
        ex_ir   = (!ob_ov || ior) && !m_busy && !rst;
        ex_have = 0;
        if (rst) begin
            exp_q.delete();
            m_acc = '0;
            m_busy = 0;
        end else begin
            if (ob_xfer && exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                ex_have = 1;
                if (ex.am) begin
                    m_acc = ex.s;
                    m_busy = 0;
                end
            end
            if (ob_acc) begin
                exp_q.push_back(model(ix, iam ? m_acc : iy, ici, isub, iam));
                if (iam) m_busy = 1;
            end
            if (iclr) m_acc = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({ob_ov, ob_s, ob_c, ob_ovf} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got ov=%b s=%h c=%b ovf=%b exp all 0", ob_ov, ob_s, ob_c, ob_ovf);
        end
        checks++;
        if (ob_ir !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=0", ob_ir);
        end
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (ob_ir !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b exp=1", ob_ir);
        end
    endtask

    task automatic test_directed();
        logic [7:0] dx [5] = '{8'h7F, 8'h0F, 8'hFF, 8'h05, 8'h80};
        logic [7:0] dy [5] = '{8'h01, 8'h01, 8'h00, 8'h07, 8'h01};
        logic       dc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       ds [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef ADDER_SAT_EN
        logic [7:0] es [5] = '{8'h7F, 8'h10, 8'h00, 8'hFE, 8'h80};
`else
        logic [7:0] es [5] = '{8'h80, 8'h10, 8'h00, 8'hFE, 8'h7F};
`endif
        logic       ec [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       eo [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(1, dx[i], dy[i], dc[i], ds[i], 0, 0, 1);
            checks++;
            if (!ob_acc) begin
                failures++;
                $display("FAIL dir_accept[%0d] got in_ready=%b exp=1", i, ob_ir);
            end
            step(0, 0, 0, 0, 0, 0, 0, 1);
            checks++;
            if (ob_ov !== 1'b0) begin
                failures++;
                $display("FAIL dir_latency1[%0d] got out_valid=%b exp=0", i, ob_ov);
            end
            step(0, 0, 0, 0, 0, 0, 0, 1);
            checks++;
            if (ob_ov !== 1'b1) begin
                failures++;
                $display("FAIL dir_latency2[%0d] got out_valid=%b exp=1", i, ob_ov);
            end
            checks++;
            if ({ob_s, ob_c, ob_ovf} !== {es[i], ec[i], eo[i]} || !ex_have ||
                {ob_s, ob_c, ob_ovf} !== {ex.s, ex.c, ex.ovf}) begin
                failures++;
                $display("FAIL dir_result[%0d] got s=%h c=%b ovf=%b exp s=%h c=%b ovf=%b",
                         i, ob_s, ob_c, ob_ovf, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bx [5];
        logic [7:0] by [5];
        logic       bs [5];
        int acc_n = 0;
        int got = 0;
        for (int i = 0; i < 5; i++) begin
            bx[i] = 8'($urandom); by[i] = 8'($urandom); bs[i] = 1'($urandom);
        end
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            int k;
            k = (acc_n < 5) ? acc_n : 0;
            step(acc_n < 5, bx[k], by[k], 0, bs[k], 0, 0, cyc >= 4);
            checks++;
            if (ob_ir !== ex_ir) begin
                failures++;
                $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, ob_ir, ex_ir);
            end
            if (cyc < 2) begin
                checks++;
                if (!ob_acc) begin
                    failures++;
                    $display("FAIL b2b_fill cyc=%0d got accept=%b exp=1", cyc, ob_acc);
                end
            end
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (ob_ir !== 1'b0 || ob_ov !== 1'b1 || exp_q.size() == 0 || ob_s !== exp_q[0].s) begin
                    failures++;
                    $display("FAIL b2b_stall cyc=%0d got in_ready=%b out_valid=%b s=%h exp 0/1/held head",
                             cyc, ob_ir, ob_ov, ob_s);
                end
            end
            if (ob_acc) acc_n++;
            if (ob_xfer) begin
                got++;
                checks++;
                if (!ex_have || {ob_s, ob_c, ob_ovf} !== {ex.s, ex.c, ex.ovf}) begin
                    failures++;
                    $display("FAIL b2b_result[%0d] got s=%h c=%b ovf=%b exp s=%h c=%b ovf=%b",
                             got, ob_s, ob_c, ob_ovf, ex.s, ex.c, ex.ovf);
                end
            end
        end
        checks++;
        if (got != 5) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=5", got);
        end
    endtask

    task automatic test_acc();
        step(0, 0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            bit done = 0;
            step(1, 8'd3, 8'($urandom), 0, 0, 1, 0, 1);
            checks++;
            if (!ob_acc) begin
                failures++;
                $display("FAIL acc_accept[%0d] got in_ready=%b exp=1", k, ob_ir);
            end
            for (int t = 0; t < 10 && !done; t++) begin
                step(1, 8'd3, 8'd0, 0, 0, 1, 0, 1);
                checks++;
                if (ob_ir !== 1'b0) begin
                    failures++;
                    $display("FAIL acc_busy[%0d] got in_ready=%b exp=0", k, ob_ir);
                end
                if (ob_xfer) begin
                    done = 1;
                    checks++;
                    if (ob_s !== 8'(3 * (k + 1)) || !ex_have || ob_s !== ex.s) begin
                        failures++;
                        $display("FAIL acc_result[%0d] got s=%h exp=%h", k, ob_s, 8'(3 * (k + 1)));
                    end
                end
            end
            checks++;
            if (!done) begin
                failures++;
                $display("FAIL acc_timeout[%0d] got no transfer exp transfer", k);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        bit done = 0;
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 8'd9, 8'd0, 0, 0, 1, 0, 1);
        for (int t = 0; t < 10 && !done; t++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            if (ob_xfer) done = 1;
        end
        checks++;
        if (!done || ob_s !== 8'd9) begin
            failures++;
            $display("FAIL mid_acc_load got done=%b s=%h exp s=09", done, ob_s);
        end
        step(1, 8'($urandom), 8'($urandom), 0, 0, 0, 0, 0);
        step(1, 8'($urandom), 8'($urandom), 0, 1, 0, 0, 0);
        checks++;
        if (!ob_acc) begin
            failures++;
            $display("FAIL mid_fill got accept=%b exp=1", ob_acc);
        end
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (ob_ov !== 1'b0 || ob_ir !== 1'b1) begin
            failures++;
            $display("FAIL mid_after_rst got out_valid=%b in_ready=%b exp 0/1", ob_ov, ob_ir);
        end
        for (int t = 0; t < 5; t++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            checks++;
            if (ob_ov !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale[%0d] got out_valid=%b exp=0", t, ob_ov);
            end
        end
        done = 0;
        step(1, 8'd0, 8'hAA, 0, 0, 1, 0, 1);
        for (int t = 0; t < 10 && !done; t++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            if (ob_xfer) done = 1;
        end
        checks++;
        if (!done || ob_s !== 8'd0 || !ex_have || ob_s !== ex.s) begin
            failures++;
            $display("FAIL mid_acc_cleared got done=%b s=%h exp s=00", done, ob_s);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            checks++;
            if (ob_ir !== ex_ir) begin
                failures++;
                $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, ob_ir, ex_ir);
            end
            if (ob_xfer) begin
                checks++;
                if (!ex_have || {ob_s, ob_c, ob_ovf} !== {ex.s, ex.c, ex.ovf}) begin
                    failures++;
                    $display("FAIL rnd_result cyc=%0d got s=%h c=%b ovf=%b exp s=%h c=%b ovf=%b have=%b",
                             cyc, ob_s, ob_c, ob_ovf, ex.s, ex.c, ex.ovf, ex_have);
                end
            end
        end
        for (int t = 0; t < 20; t++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            if (ob_xfer) begin
                checks++;
                if (!ex_have || {ob_s, ob_c, ob_ovf} !== {ex.s, ex.c, ex.ovf}) begin
                    failures++;
                    $display("FAIL rnd_drain got s=%h c=%b ovf=%b exp s=%h c=%b ovf=%b",
                             ob_s, ob_c, ob_ovf, ex.s, ex.c, ex.ovf);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rnd_lost got pending=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_acc();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
